regfile: RTL and testbench



---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_if.sv | 31 +++
 rtl/regfile_rd_mux.sv | 13 +
 rtl/regfile.sv | 48 ++++
 tb/tb_regfile.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Register file shared package: widths, select type and storage array type.
// Imported by the interface, the read mux and the register file top.
package regfile_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int NREGS  = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_sel_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [NREGS-1:0][DATA_W-1:0] reg_arr_t;

endpackage

// File: rtl/regfile_if.sv
// Register file port bundle: two write ports (we/sel/data), two read ports.
// master drives writes and read selects; slave (the regfile) returns read data.
interface regfile_if;
   import regfile_pkg::*;

   logic     in1_we;
   reg_sel_t in1_sel;
   data_t    in1_data;
   logic     in2_we;
   reg_sel_t in2_sel;
   data_t    in2_data;
   reg_sel_t out1_sel;
   data_t    out1_data;
   reg_sel_t out2_sel;
   data_t    out2_data;

   modport master (
      output in1_we, in1_sel, in1_data,
      output in2_we, in2_sel, in2_data,
      output out1_sel, out2_sel,
      input  out1_data, out2_data
   );

   modport slave (
      input  in1_we, in1_sel, in1_data,
      input  in2_we, in2_sel, in2_data,
      input  out1_sel, out2_sel,
      output out1_data, out2_data
   );

endinterface

// File: rtl/regfile_rd_mux.sv
// NREGS:1 combinational read mux for one register file read port.
// Ports: regs (flattened storage), sel (source register), data (selected word).
module regfile_rd_mux
   import regfile_pkg::*;
(
   input  reg_arr_t regs,
   input  reg_sel_t sel,
   output data_t    data
);

   assign data = regs[sel];

endmodule

// File: rtl/regfile.sv
// 16x16 register file: two synchronous write ports, two async read ports.
// Ports: clk, rst_n (async active-low clear), bus (regfile_if.slave).
module regfile
   import regfile_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   regfile_if.slave  bus
);

   reg_arr_t regs_q;
   reg_arr_t regs_d;

   // Per-register decode gated by the enable, so a garbage select with
   // we=0 can never match. Port 2 is evaluated last and wins collisions.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.in1_we && (bus.in1_sel == reg_sel_t'(i))) begin
            regs_d[i] = bus.in1_data;
         end
         if (bus.in2_we && (bus.in2_sel == reg_sel_t'(i))) begin
            regs_d[i] = bus.in2_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   regfile_rd_mux u_rd_mux1 (
      .regs (regs_q),
      .sel  (bus.out1_sel),
      .data (bus.out1_data)
   );

   regfile_rd_mux u_rd_mux2 (
      .regs (regs_q),
      .sel  (bus.out2_sel),
      .data (bus.out2_data)
   );

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile.
// One task per scenario; expected values are hand-computed constants.
module tb_regfile;
   import regfile_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   regfile_if bus ();

   regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.in1_we   = 1'b0;
      bus.in1_sel  = '0;
      bus.in1_data = '0;
      bus.in2_we   = 1'b0;
      bus.in2_sel  = '0;
      bus.in2_data = '0;
   endtask

   // Drive both write ports on a falling edge, let one rising edge commit.
   task automatic do_write(
      input logic     we1,
      input reg_sel_t s1,
      input data_t    d1,
      input logic     we2,
      input reg_sel_t s2,
      input data_t    d2
   );
      @(negedge clk);
      bus.in1_we   = we1;
      bus.in1_sel  = s1;
      bus.in1_data = d1;
      bus.in2_we   = we2;
      bus.in2_sel  = s2;
      bus.in2_data = d2;
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   task automatic test_reset();
      for (int i = 0; i < NREGS; i++) begin
         bus.out1_sel = reg_sel_t'(i);
         bus.out2_sel = reg_sel_t'(NREGS - 1 - i);
         #1;
         checks++;
         if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_read sel=%0d got %h/%h want 0000/0000",
                     i, bus.out1_data, bus.out2_data);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out1_sel = 4'd3;
      bus.out2_sel = 4'd12;
      #1;
      checks++;
      if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_release got %h/%h want 0000/0000",
                  bus.out1_data, bus.out2_data);
      end
   endtask

   task automatic test_dual_write();
      bus.out1_sel = 4'd1;
      bus.out2_sel = 4'd2;
      @(negedge clk);
      bus.in1_we   = 1'b1;
      bus.in1_sel  = 4'd1;
      bus.in1_data = 16'hDEAD;
      bus.in2_we   = 1'b1;
      bus.in2_sel  = 4'd2;
      bus.in2_data = 16'hBEEF;
      #1;
      checks++;
      if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
         errors++;
         $display("FAIL dual_pre_edge got %h/%h want 0000/0000",
                  bus.out1_data, bus.out2_data);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out1_data !== 16'hDEAD || bus.out2_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL dual_post_edge got %h/%h want DEAD/BEEF",
                  bus.out1_data, bus.out2_data);
      end
      drive_idle();
   endtask

   task automatic test_disabled_write();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.in1_we   = 1'b0;
         bus.in2_we   = 1'b0;
         bus.in1_sel  = 'x;
         bus.in2_sel  = 'x;
         bus.in1_data = data_t'($urandom);
         bus.in2_data = data_t'($urandom);
      end
      @(posedge clk);
      #1;
      drive_idle();
      bus.out1_sel = 4'd1;
      bus.out2_sel = 4'd2;
      #1;
      checks++;
      if (bus.out1_data !== 16'hDEAD || bus.out2_data !== 16'hBEEF) begin
         errors++;
         $display("FAIL disabled_keep got %h/%h want DEAD/BEEF",
                  bus.out1_data, bus.out2_data);
      end
      bus.out1_sel = 4'd4;
      bus.out2_sel = 4'd5;
      #1;
      checks++;
      if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
         errors++;
         $display("FAIL disabled_unwritten got %h/%h want 0000/0000",
                  bus.out1_data, bus.out2_data);
      end
   endtask

   task automatic test_collision();
      do_write(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222);
      bus.out1_sel = 4'd7;
      bus.out2_sel = 4'd7;
      #1;
      checks++;
      if (bus.out1_data !== 16'h2222 || bus.out2_data !== 16'h2222) begin
         errors++;
         $display("FAIL collision got %h/%h want 2222/2222",
                  bus.out1_data, bus.out2_data);
      end
   endtask

   task automatic test_async_read();
      for (int i = 0; i < NREGS; i += 2) begin
         do_write(1'b1, reg_sel_t'(i), data_t'(16'hA000 + i),
                  1'b1, reg_sel_t'(i + 1), data_t'(16'hA000 + i + 1));
      end
      for (int i = 0; i < NREGS; i++) begin
         bus.out1_sel = reg_sel_t'(i);
         bus.out2_sel = reg_sel_t'(NREGS - 1 - i);
         #1;
         checks++;
         if (bus.out1_data !== data_t'(16'hA000 + i) ||
             bus.out2_data !== data_t'(16'hA000 + NREGS - 1 - i)) begin
            errors++;
            $display("FAIL async_read i=%0d got %h/%h want %h/%h",
                     i, bus.out1_data, bus.out2_data,
                     16'hA000 + i, 16'hA000 + NREGS - 1 - i);
         end
      end
   endtask

   task automatic test_boundary();
      do_write(1'b1, 4'd0, 16'h0F0F, 1'b1, 4'd15, 16'hF0F0);
      bus.out1_sel = 4'd0;
      bus.out2_sel = 4'd15;
      #1;
      checks++;
      if (bus.out1_data !== 16'h0F0F || bus.out2_data !== 16'hF0F0) begin
         errors++;
         $display("FAIL boundary got %h/%h want 0F0F/F0F0",
                  bus.out1_data, bus.out2_data);
      end
      bus.out1_sel = 4'd8;
      bus.out2_sel = 4'd8;
      #1;
      checks++;
      if (bus.out1_data !== 16'hA008 || bus.out2_data !== 16'hA008) begin
         errors++;
         $display("FAIL boundary_other got %h/%h want A008/A008",
                  bus.out1_data, bus.out2_data);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.in1_we   = 1'b1;
      bus.in1_sel  = 4'd3;
      bus.in1_data = 16'hFFFF;
      for (int i = 0; i < NREGS; i++) begin
         bus.out1_sel = reg_sel_t'(i);
         bus.out2_sel = reg_sel_t'(NREGS - 1 - i);
         #1;
         checks++;
         if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset sel=%0d got %h/%h want 0000/0000",
                     i, bus.out1_data, bus.out2_data);
         end
      end
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out1_sel = 4'd3;
      bus.out2_sel = 4'd0;
      #1;
      checks++;
      if (bus.out1_data !== 16'h0000 || bus.out2_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_write_ignored got %h/%h want 0000/0000",
                  bus.out1_data, bus.out2_data);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      drive_idle();
      bus.out1_sel = '0;
      bus.out2_sel = '0;
      #1;
      test_reset();
      test_dual_write();
      test_disabled_write();
      test_collision();
      test_async_read();
      test_boundary();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
